fifo_word_reader: RTL

//   Read-side consumer for the 8-bit byte FIFO (fifo, ENTRIES deep).
//   - Pops bytes with the FIFO's read strobe and never pops while the FIFO reports empty.
//   - Absorbs the FIFO's 1-cycle registered read latency.
//   - Packs 4 bytes little-endian into a 32-bit word and offers it downstream on a valid/ready handshake.

---
 rtl/fifo_word_reader_if.sv | 39 +++
 rtl/fifo_word_reader.sv | 108 ++++++++++
 2 files changed

// File: rtl/fifo_word_reader_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fifo_word_reader_if                                                      |
// | Byte-FIFO read port plus 32-bit word valid/ready port of the reader.     |
// | Optional flush signals exist only when FIFO_READER_FLUSH_EN is defined.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface fifo_word_reader_if;
    logic        in_fifo_empty;
    logic [7:0]  in_fifo_data;
    logic        out_fifo_read;
    logic        out_word_valid;
    logic [31:0] out_word_data;
    logic        in_word_ready;
    logic        out_busy;
`ifdef FIFO_READER_FLUSH_EN
    logic        in_flush;
    logic [2:0]  out_word_bytes;

    modport master (
        input  in_fifo_empty, in_fifo_data, in_word_ready, in_flush,
        output out_fifo_read, out_word_valid, out_word_data, out_busy, out_word_bytes
    );
    modport slave (
        output in_fifo_empty, in_fifo_data, in_word_ready, in_flush,
        input  out_fifo_read, out_word_valid, out_word_data, out_busy, out_word_bytes
    );
`else
    modport master (
        input  in_fifo_empty, in_fifo_data, in_word_ready,
        output out_fifo_read, out_word_valid, out_word_data, out_busy
    );
    modport slave (
        output in_fifo_empty, in_fifo_data, in_word_ready,
        input  out_fifo_read, out_word_valid, out_word_data, out_busy
    );
`endif
endinterface
`default_nettype wire

// File: rtl/fifo_word_reader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fifo_word_reader                                                         |
// | Pops an 8-bit FIFO (1-cycle read latency) and packs 4 bytes LE into a    |
// | 32-bit valid/ready word. FIFO_READER_FLUSH_EN adds partial-word flush.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module fifo_word_reader #(
    parameter int WORD_BYTES = 4
) (
    input  wire                clk,
    input  wire                rst,
    fifo_word_reader_if.master bus
);
    typedef enum logic [0:0] {
        ST_FILL = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    localparam logic [2:0] c_word_bytes = 3'(WORD_BYTES);

    state_t      r_state;
    logic [2:0]  r_issued;
    logic [2:0]  r_captured;
    logic        r_pend;
    logic        r_valid;
    logic [31:0] r_data;
    logic        w_read;
`ifdef FIFO_READER_FLUSH_EN
    logic        r_flush_req;
    logic [2:0]  r_word_bytes;
`endif

    always_comb begin
        w_read = ~rst & ~bus.in_fifo_empty & (r_state == ST_FILL) & (r_issued < c_word_bytes);
`ifdef FIFO_READER_FLUSH_EN
        w_read = w_read & ~r_flush_req;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_FILL;
            r_issued   <= 3'd0;
            r_captured <= 3'd0;
            r_pend     <= 1'b0;
            r_valid    <= 1'b0;
            r_data     <= 32'd0;
`ifdef FIFO_READER_FLUSH_EN
            r_flush_req  <= 1'b0;
            r_word_bytes <= 3'd0;
`endif
        end else if (r_state == ST_FILL) begin
            r_pend <= w_read;
            if (w_read) begin
                r_issued <= r_issued + 3'd1;
            end
            // pend marks that the FIFO presents the byte popped last cycle
            if (r_pend) begin
                r_data[{r_captured[1:0], 3'b000} +: 8] <= bus.in_fifo_data;
                r_captured <= r_captured + 3'd1;
                if (r_captured == c_word_bytes - 3'd1) begin
                    r_state <= ST_HOLD;
                    r_valid <= 1'b1;
`ifdef FIFO_READER_FLUSH_EN
                    r_word_bytes <= c_word_bytes;
`endif
                end
            end
`ifdef FIFO_READER_FLUSH_EN
            else if (r_flush_req) begin
                // no read in flight: emit what we have, or drop an empty flush
                if (r_captured != 3'd0) begin
                    r_state      <= ST_HOLD;
                    r_valid      <= 1'b1;
                    r_word_bytes <= r_captured;
                end else begin
                    r_flush_req <= 1'b0;
                end
            end
            if (bus.in_flush) begin
                r_flush_req <= 1'b1;
            end
`endif
        end else begin
            if (bus.in_word_ready) begin
                r_state    <= ST_FILL;
                r_valid    <= 1'b0;
                r_issued   <= 3'd0;
                r_captured <= 3'd0;
                r_data     <= 32'd0;
`ifdef FIFO_READER_FLUSH_EN
                r_flush_req  <= 1'b0;
                r_word_bytes <= 3'd0;
`endif
            end
        end
    end

    assign bus.out_fifo_read  = w_read;
    assign bus.out_word_valid = r_valid;
    assign bus.out_word_data  = r_data;
    assign bus.out_busy       = (r_issued != 3'd0) | r_pend | r_valid;
`ifdef FIFO_READER_FLUSH_EN
    assign bus.out_word_bytes = r_word_bytes;
`endif
endmodule
`default_nettype wire
